commit_trace_collector: RTL
===========================

# commit_trace_collector

Parametrised commit-trace capture block for the CPU verification environment. Each cycle it samples the architectural side effects of up to `LANES` issue lanes: GPR writes, HI/LO writes and data-bus stores. Every event is stamped with a cycle number, and the events are serialised in a fixed priority order into an internal FIFO. A single-entry-per-cycle valid/ready stream drains the FIFO to a checker, logger or UART dumper. It supersedes per-lane ad-hoc monitoring: lane count and FIFO depth are generic, and it adds backpressure, buffering and overflow accounting.

## Interface
Parameters:
- `LANES`, 2, number of commit lanes sampled (1..4).
- `DEPTH`, 16, FIFO entries; power of two, at least 3*`LANES`.
- `CYC_W`, 32, width of the cycle stamp.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  sampling enable; when 0, no events are captured, but the cycle counter still runs.
- `reg_we`  in  LANES  per-lane GPR write enable.
- `reg_waddr`  in  LANES×5  per-lane GPR index.
- `reg_wdata`  in  LANES×32  per-lane GPR data.
- `hilo_we`  in  LANES  per-lane HI/LO write enable.
- `hilo_wdata`  in  LANES×64  per-lane {HI,LO}.
- `mem_we`  in  LANES  per-lane store commit.
- `mem_addr`  in  LANES×32  store address, word-aligned by the source.
- `mem_wdata`  in  LANES×32  store data.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts head.
- `out_event`  out  TraceEvent_t  head entry {kind, lane, addr, data, cycle}.
- `overflow`  out  1  sticky; set when any event has been dropped.
- `drop_count`  out  16  dropped events, saturating at 0xFFFF.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Cycle counter `cyc`: reset value 0, increments on every edge, wraps at 2^CYC_W. Events sampled on an edge are stamped `cyc+1`, so the first edge after reset is cycle 1.
- Event kinds: MEM=3, REG=1, HILO=2.
- A REG event with `reg_waddr==0` is discarded. It is not counted as a drop.
- Field mapping:
  - REG: addr = zero-extended index, data = {32'b0, wdata}.
  - MEM: addr = `mem_addr`, data = {32'b0, wdata}.
  - HILO: addr = 0, data = `hilo_wdata`.
- Serialisation order within one cycle: lane 0 MEM, lane 0 REG, lane 0 HILO, lane 1 MEM, and so on. Only the valid events are compacted, in that order, into consecutive FIFO slots.
- Push is all-or-nothing per cycle:
  - Let n = number of valid events and free = DEPTH − level (pre-edge value).
  - If n ≤ free, all n events are written.
  - Otherwise none are written, `overflow` is set to 1, and `drop_count` increases by n (saturating).
- A pop in the same cycle does not add free space for that cycle's push decision.
- Pop: the head is removed when `out_valid && out_ready`. `out_event` is held stable while `out_valid && !out_ready`.
- `level` update per edge: level + pushed − popped.
- Reset (asynchronous, any time, including mid-drain) has these effects:
  - FIFO empties, `out_valid`=0, `level`=0.
  - `overflow`=0, `drop_count`=0, `cyc`=0.
  - `out_event` = all-zero.

## Timing
- Capture-to-output latency is 1 edge. Events sampled on edge k are visible on `out_valid` after edge k if the FIFO was empty before that edge.
- Throughput: at most one pop per cycle and at most 3*LANES pushes per cycle.
- Simultaneous push and pop on an empty FIFO is impossible, because `out_valid` is 0. When the FIFO is full with pop=1, the push is still rejected (no credit, per the rule above).
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from `level`.
- The output is driven directly from the FIFO storage head (registered). There is no combinational path from the sampled inputs to the outputs.

## Structure
- Shared package `trace_pkg`:
  - `TraceKind_t` (2-bit enum: NONE=0, REG=1, HILO=2, MEM=3).
  - `TraceEvent_t` packed struct {kind, lane[1:0], addr[31:0], data[63:0], cycle[CYC_W-1:0]}; the struct width is fixed using the default `CYC_W`=32.
  - Constant `TRACE_MAX_LANES=4`.
- Sub-module `trace_fifo_mpush`: a multi-push, single-pop FIFO.
  - Inputs: `push_n` and a compacted array of 3*LANES entries.
  - Outputs: `level`, head, and an accept flag.
- The top level holds the lane compaction (prefix count of valid bits), the cycle counter and the drop accounting.

## Test plan
- **Reset values:** assert `rst` for 3 cycles, then release → `out_valid`=0, `level`=0, `overflow`=0, `drop_count`=0. The first sampled event carries cycle=1.
- **Single event and $0 filter:**
  - Lane 0 REG $3=0x00001234 sampled on edge 5 → one entry {REG, lane0, addr 3, data 0x1234, cycle 5}. `out_valid` is high after edge 5.
  - $0 write on the same lane at edge 6 → no entry.
- **Full ordering (LANES=2):** all 6 events in one cycle with `out_ready`=1 → six pops in order MEM0, REG0, HILO0, MEM1, REG1, HILO1, all with the same cycle stamp. `level` goes 6→5→…→0.
- **Overflow (DEPTH=16):** `out_ready`=0, 6 events per cycle for 3 cycles → `level`=12 after 2 cycles. The third batch is dropped whole: `level`=12, `overflow`=1, `drop_count`=6.
- **Backpressure hold:** `out_ready` toggles 0/1 every cycle → `out_event` is stable whenever it is not accepted, and the entry sequence has no duplicates or gaps.
- **Reset mid-drain:** `rst` pulsed asynchronously (mid-cycle) with `level`=5 → outputs clear immediately, without waiting for an edge. After release, new events restart at cycle 1.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the commit-trace capture path: event kinds, the event record
// and lane limits.
package trace_pkg;

  localparam int unsigned TRACE_MAX_LANES = 4;
  localparam int unsigned TRACE_CYC_W     = 32;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    REG  = 2'd1,
    HILO = 2'd2,
    MEM  = 2'd3
  } TraceKind_t;

  typedef struct packed {
    TraceKind_t             kind;
    logic [1:0]             lane;
    logic [31:0]            addr;
    logic [63:0]            data;
    logic [TRACE_CYC_W-1:0] cycle;
  } TraceEvent_t;

endpackage

// File: rtl/trace_fifo_mpush.sv
// Multi-push, single-pop FIFO of trace events. A batch of push_n compacted
// entries is written all-or-nothing against the pre-edge free space.
module trace_fifo_mpush
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NPUSH = 6,
  parameter int unsigned CNT_W = $clog2(NPUSH + 1),
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        push_n,
  input  TraceEvent_t [NPUSH-1:0] push_data,
  input  logic                    pop,
  output logic                    valid,
  output TraceEvent_t             head,
  output logic [LVL_W-1:0]        level,
  output logic                    accept
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  TraceEvent_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_free;
  logic [LVL_W-1:0] w_push_cnt;
  logic             w_valid;
  logic             w_pop;

  // A same-cycle pop never lends space to the push decision.
  assign w_free     = LVL_W'(DEPTH) - r_level;
  assign accept     = (LVL_W'(push_n) <= w_free);
  assign w_push_cnt = accept ? LVL_W'(push_n) : '0;
  assign w_valid    = (r_level != '0);
  assign w_pop      = pop && w_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_level  <= r_level + w_push_cnt - LVL_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPUSH; i++) begin
      if (accept && (CNT_W'(i) < push_n)) begin
        r_mem[r_wr_ptr + PTR_W'(i)] <= push_data[i];
      end
    end
  end

  assign valid = w_valid;
  assign head  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign level = r_level;

endmodule

// File: rtl/commit_trace_collector.sv
// Samples per-lane GPR, HI/LO and store commits, stamps them with a cycle
// number and serialises them into a FIFO drained by a valid/ready stream.
module commit_trace_collector
  import trace_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CYC_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [LANES-1:0]          reg_we,
  input  logic [LANES*5-1:0]        reg_waddr,
  input  logic [LANES*32-1:0]       reg_wdata,
  input  logic [LANES-1:0]          hilo_we,
  input  logic [LANES*64-1:0]       hilo_wdata,
  input  logic [LANES-1:0]          mem_we,
  input  logic [LANES*32-1:0]       mem_addr,
  input  logic [LANES*32-1:0]       mem_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output TraceEvent_t               out_event,
  output logic                      overflow,
  output logic [15:0]               drop_count,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned NSLOT = 3 * LANES;
  localparam int unsigned CNT_W = $clog2(NSLOT + 1);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [CYC_W-1:0]        r_cyc;
  logic [CYC_W-1:0]        w_cyc_next;
  logic                    r_overflow;
  logic [15:0]             r_drop;
  logic [16:0]             w_drop_sum;
  TraceEvent_t [NSLOT-1:0] w_cand;
  logic [NSLOT-1:0]        w_cand_v;
  TraceEvent_t [NSLOT-1:0] w_packed;
  logic [CNT_W-1:0]        w_push_n;
  logic                    w_accept;

  assign w_cyc_next = r_cyc + CYC_W'(1);

  // Candidate slots per lane in serialisation order: MEM, REG, HILO.
  always_comb begin
    w_cand   = '0;
    w_cand_v = '0;
    for (int l = 0; l < LANES; l++) begin
      w_cand[3*l].kind    = MEM;
      w_cand[3*l].lane    = 2'(l);
      w_cand[3*l].addr    = mem_addr[32*l +: 32];
      w_cand[3*l].data    = {32'b0, mem_wdata[32*l +: 32]};
      w_cand[3*l].cycle   = TRACE_CYC_W'(w_cyc_next);
      w_cand_v[3*l]       = enable && mem_we[l];

      w_cand[3*l+1].kind  = REG;
      w_cand[3*l+1].lane  = 2'(l);
      w_cand[3*l+1].addr  = {27'b0, reg_waddr[5*l +: 5]};
      w_cand[3*l+1].data  = {32'b0, reg_wdata[32*l +: 32]};
      w_cand[3*l+1].cycle = TRACE_CYC_W'(w_cyc_next);
      w_cand_v[3*l+1]     = enable && reg_we[l] && (reg_waddr[5*l +: 5] != 5'd0);

      w_cand[3*l+2].kind  = HILO;
      w_cand[3*l+2].lane  = 2'(l);
      w_cand[3*l+2].addr  = 32'b0;
      w_cand[3*l+2].data  = hilo_wdata[64*l +: 64];
      w_cand[3*l+2].cycle = TRACE_CYC_W'(w_cyc_next);
      w_cand_v[3*l+2]     = enable && hilo_we[l];
    end
  end

  // Compaction: each valid slot lands at the running count of valid slots before it.
  always_comb begin : compact_p
    logic [CNT_W-1:0] v_n;
    v_n      = '0;
    w_packed = '0;
    for (int j = 0; j < NSLOT; j++) begin
      if (w_cand_v[j]) begin
        w_packed[v_n] = w_cand[j];
        v_n           = v_n + CNT_W'(1);
      end
    end
    w_push_n = v_n;
  end

  assign w_drop_sum = {1'b0, r_drop} + 17'(w_push_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc      <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_cyc <= w_cyc_next;
      if ((w_push_n != '0) && !w_accept) begin
        r_overflow <= 1'b1;
        r_drop     <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end

  trace_fifo_mpush #(
    .DEPTH (DEPTH),
    .NPUSH (NSLOT),
    .CNT_W (CNT_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_n    (w_push_n),
    .push_data (w_packed),
    .pop       (out_ready),
    .valid     (out_valid),
    .head      (out_event),
    .level     (level),
    .accept    (w_accept)
  );

  assign overflow   = r_overflow;
  assign drop_count = r_drop;

endmodule
